// File: rtl/pipe_div_pkg.sv
// Shared types and constants for the pipeline quotient divider.
// Pipeline-result back-calculation uses the default operand width.
package pipe_div_pkg;

  localparam int unsigned DIV_N = 10;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DIV_N);

  // Quotient reported when the captured divisor is zero.
  localparam logic [DIV_N-1:0] QUO_ONES = '1;

endpackage

// File: rtl/pipe_quotient_divider_div_step.sv
// One combinational restoring-division step: shift {rem, quo} left,
// trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int unsigned N = 10
) (
  input  logic [N:0]   rem_i,
  input  logic [N-1:0] quo_i,
  input  logic [N-1:0] div_i,
  output logic [N:0]   rem_o,
  output logic [N-1:0] quo_o
);

  logic [N:0]   shifted;
  logic [N+1:0] diff;

  always_comb begin
    shifted = {rem_i[N-1:0], quo_i[N-1]};
    // Extra MSB acts as the borrow flag of the trial subtraction.
    diff    = {1'b0, shifted} - {2'b00, div_i};
    if (!diff[N+1]) begin
      rem_o = diff[N:0];
      quo_o = {quo_i[N-2:0], 1'b1};
    end else begin
      rem_o = shifted;
      quo_o = {quo_i[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/pipe_quotient_divider.sv
// Sequential restoring divider recovering q = floor(f/d), r = f - q*d,
// one quotient bit per clock, with valid/ready on both sides.
module pipe_quotient_divider
  import pipe_div_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] f,
  input  logic [N-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         div_by_zero
);

  localparam int unsigned CntW = cnt_width(N);

  state_e        state_q;
  logic [CntW-1:0] cnt_q;
  logic [N:0]    rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  div_q;
  logic [N:0]    rem_nxt;
  logic [N-1:0]  quo_nxt;

  div_step #(
    .N(N)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(div_q),
    .rem_o(rem_nxt),
    .quo_o(quo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            quo_q    <= f;
            div_q    <= d;
            rem_q    <= '0;
            cnt_q    <= CntW'(N);
            in_ready <= 1'b0;
            if (d == '0) begin
              state_q     <= StDone;
              q           <= {N{1'b1}};
              r           <= f;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - CntW'(1);
          // Final step: publish the result straight from the step outputs.
          if (cnt_q == CntW'(1)) begin
            state_q     <= StDone;
            q           <= quo_nxt;
            r           <= rem_nxt[N-1:0];
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_quotient_divider.sv
// Self-checking bench for pipe_quotient_divider: directed cases plus a
// random sweep against an arithmetic reference model.
module tb_pipe_quotient_divider;

  localparam int N = 10;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] f;
  logic [N-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         div_by_zero;

  int n_checks;
  int n_errors;
  int hs_count;

  pipe_quotient_divider #(
    .N(N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .f          (f),
    .d          (d),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .q          (q),
    .r          (r),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) hs_count <= hs_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one operand pair; returns at the negedge after the capture edge.
  task automatic send(input logic [N-1:0] ff, input logic [N-1:0] dd);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("send_in_ready", 32'(in_ready), 32'd1);
    f        = ff;
    d        = dd;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Latency counted in edges, the capture edge being the first.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("take_out_valid_low", 32'(out_valid), 32'd0);
    check("take_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_case(input string tag, input logic [N-1:0] ff, input logic [N-1:0] dd);
    int lat;
    int eq;
    int er;
    int ez;
    ez = (dd == 0) ? 1 : 0;
    eq = (dd == 0) ? (1 << N) - 1 : int'(ff) / int'(dd);
    er = (dd == 0) ? int'(ff) : int'(ff) % int'(dd);
    send(ff, dd);
    wait_result(lat);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat"}, 32'(lat), (dd == 0) ? 32'd1 : 32'(N + 1));
    check({tag, "_q"}, 32'(q), 32'(eq));
    check({tag, "_r"}, 32'(r), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    take();
  endtask

  initial begin
    int lat;
    int hs_base;
    int done;
    int guard;
    int ro;
    int sel;
    logic [N-1:0] ff;
    logic [N-1:0] dd;
    int eq;
    int er;
    int ez;

    n_checks  = 0;
    n_errors  = 0;
    hs_count  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    f         = '0;
    d         = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_q", 32'(q), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    run_case("d1000_7", 10'd1000, 10'd7);
    run_case("d0_5", 10'd0, 10'd5);
    run_case("d1023_1", 10'd1023, 10'd1);
    run_case("d3_1000", 10'd3, 10'd1000);
    run_case("dz77", 10'd77, 10'd0);
    run_case("d9_3", 10'd9, 10'd3);

    // Backpressure: result must hold while a competing request is ignored.
    send(10'd500, 10'd9);
    wait_result(lat);
    check("bp_lat", 32'(lat), 32'(N + 1));
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_q", 32'(q), 32'd55);
      check("bp_r", 32'(r), 32'd5);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      f        = 10'd1;
      d        = 10'd1;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_q_end", 32'(q), 32'd55);
    check("bp_r_end", 32'(r), 32'd5);
    take();
    repeat (2) begin
      @(negedge clk);
      check("bp_no_capture", 32'(out_valid), 32'd0);
      check("bp_idle_ready", 32'(in_ready), 32'd1);
    end

    // Reset during RUN cycle 4 discards the in-flight result.
    send(10'd600, 10'd7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_q", 32'(q), 32'd0);
    check("mid_rst_r", 32'(r), 32'd0);
    check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    run_case("d100_10", 10'd100, 10'd10);

    // Random sweep with randomly stalled consumer.
    hs_base = hs_count;
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 7);
      ff  = N'($urandom_range(0, (1 << N) - 1));
      if (sel == 0) dd = '0;
      else if (sel == 1) dd = N'($urandom_range(1, 15));
      else dd = N'($urandom_range(0, (1 << N) - 1));
      ez = (dd == 0) ? 1 : 0;
      eq = (dd == 0) ? (1 << N) - 1 : int'(ff) / int'(dd);
      er = (dd == 0) ? int'(ff) : int'(ff) % int'(dd);
      send(ff, dd);
      wait_result(lat);
      check("sw_valid", 32'(out_valid), 32'd1);
      check("sw_lat", 32'(lat), (dd == 0) ? 32'd1 : 32'(N + 1));
      done  = 0;
      guard = 0;
      while (done == 0 && guard < 40) begin
        check("sw_hold_valid", 32'(out_valid), 32'd1);
        check("sw_q", 32'(q), 32'(eq));
        check("sw_r", 32'(r), 32'(er));
        check("sw_dbz", 32'(div_by_zero), 32'(ez));
        ro        = int'($urandom_range(0, 1));
        out_ready = ro[0];
        @(negedge clk);
        out_ready = 1'b0;
        guard++;
        if (ro != 0) done = 1;
      end
      check("sw_no_dup", 32'(out_valid), 32'd0);
    end
    check("sw_handshakes", 32'(hs_count - hs_base), 32'd2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
